fetch_bht_stage: RTL



---
 rtl/fetch_bht_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_bht_stage.sv
// Instruction-fetch stage with a direct-mapped 1-bit branch history table.
// Presents PC, instruction word, validity and predicted-taken to IF/ID.
module fetch_bht_stage #(
    parameter int          BHT_IDX_W = 3,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_IF,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        bht_upd_valid,
    input  logic [15:0] bht_upd_pc,
    input  logic        bht_upd_taken,
    input  logic [15:0] bht_upd_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] out_IW,
    output logic [15:0] out_pc,
    output logic        out_BPR,
    output logic        out_valid
);

    localparam int NE = 1 << BHT_IDX_W;
    localparam int TW = 16 - BHT_IDX_W;

    logic [15:0]          pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic [NE-1:0]        v_q;
    logic [NE-1:0]        h_q;
    logic [TW-1:0]        tag_q [NE];
    logic [15:0]          tgt_q [NE];

    logic [BHT_IDX_W-1:0] idx;
    logic [BHT_IDX_W-1:0] u;
    logic                 hit;
    logic                 pred_taken;
    logic                 upd_hit;

    assign idx        = pc_q[BHT_IDX_W-1:0];
    assign u          = bht_upd_pc[BHT_IDX_W-1:0];
    assign hit        = v_q[idx] & (tag_q[idx] == pc_q[15:BHT_IDX_W]);
    assign pred_taken = hit & h_q[idx];
    assign upd_hit    = v_q[u] & (tag_q[u] == bht_upd_pc[15:BHT_IDX_W]);

    assign imem_addr = pc_q;
    assign out_pc    = pc_q;
    assign out_IW    = imem_data;
    assign out_valid = valid_q & ~redirect_valid;
    assign out_BPR   = pred_taken & out_valid;

    // An invalid slot (startup) is refetched rather than advanced.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b1;
        end else if (!stall_IF) begin
            valid_d = 1'b1;
            if (valid_q) begin
                pc_d = pred_taken ? tgt_q[idx] : pc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            v_q <= '0;
            h_q <= '0;
        end else if (bht_upd_valid) begin
            if (bht_upd_taken) begin
                v_q[u] <= 1'b1;
                h_q[u] <= 1'b1;
            end else if (upd_hit) begin
                h_q[u] <= 1'b0;
            end
        end
    end

    // Tag and target carry no reset; v gates their use.
    always_ff @(posedge clk) begin
        if (resetn && bht_upd_valid && bht_upd_taken) begin
            tag_q[u] <= bht_upd_pc[15:BHT_IDX_W];
            tgt_q[u] <= bht_upd_target;
        end
    end

endmodule
